// File: rtl/lsq.sv
// Load/store queue: in-order circular buffer with CDB operand wakeup and a
// single outstanding memory op; stores issue only once they reach the ROB head.
module lsq #(
  parameter int DEPTH    = 8,
  parameter int ROB_BITS = 4,
  parameter int NUM_CDB  = 2
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        rdy_in,
  input  logic                        in_valid,
  input  logic                        in_is_store,
  input  logic [2:0]                  in_funct3,
  input  logic [31:0]                 in_vj,
  input  logic [31:0]                 in_vk,
  input  logic [ROB_BITS-1:0]         in_qj,
  input  logic [ROB_BITS-1:0]         in_qk,
  input  logic                        in_j_rdy,
  input  logic                        in_k_rdy,
  input  logic [31:0]                 in_imm,
  input  logic [ROB_BITS-1:0]         in_rob,
  output logic                        full,
  output logic [$clog2(DEPTH):0]      count,
  input  logic [NUM_CDB-1:0]          cdb_valid,
  input  logic [NUM_CDB*ROB_BITS-1:0] cdb_tag,
  input  logic [NUM_CDB*32-1:0]       cdb_value,
  input  logic [ROB_BITS-1:0]         rob_head,
  input  logic                        flush,
  output logic                        mem_req,
  output logic                        mem_we,
  output logic [1:0]                  mem_size,
  output logic [31:0]                 mem_addr,
  output logic [31:0]                 mem_wdata,
  input  logic                        mem_ack,
  input  logic                        mem_rvalid,
  input  logic [31:0]                 mem_rdata,
  output logic                        out_valid,
  output logic [ROB_BITS-1:0]         out_rob,
  output logic [31:0]                 out_value,
  output logic                        out_is_store,
  output logic                        out_misalign
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_REQ     = 2'd1;
  localparam logic [1:0] S_WAIT_LD = 2'd2;
  localparam logic [1:0] S_DROP    = 2'd3;

  typedef struct packed {
    logic                is_store;
    logic [2:0]          f3;
    logic [31:0]         vj;
    logic [31:0]         vk;
    logic [31:0]         imm;
    logic [ROB_BITS-1:0] qj;
    logic [ROB_BITS-1:0] qk;
    logic [ROB_BITS-1:0] rob;
    logic                j_rdy;
    logic                k_rdy;
  } ent_t;

  ent_t                r_ent [DEPTH];
  logic [DEPTH-1:0]    r_busy;
  logic [PW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_count;
  logic [1:0]          r_state;
  logic [ROB_BITS-1:0] r_cur_rob;
  logic [2:0]          r_cur_f3;
  logic                r_mem_req, r_mem_we;
  logic [1:0]          r_mem_size;
  logic [31:0]         r_mem_addr, r_mem_wdata;
  logic                r_out_valid, r_out_is_store, r_out_misalign;
  logic [ROB_BITS-1:0] r_out_rob;
  logic [31:0]         r_out_value;

  ent_t        w_head, w_new;
  logic [31:0] w_addr, w_wdata, w_ldval;
  logic [1:0]  w_size;
  logic        w_mis, w_can_issue, w_push, w_pop;

  assign full         = (r_count == FULL_CNT);
  assign count        = r_count;
  assign mem_req      = r_mem_req;
  assign mem_we       = r_mem_we;
  assign mem_size     = r_mem_size;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;
  assign out_valid    = r_out_valid;
  assign out_rob      = r_out_rob;
  assign out_value    = r_out_value;
  assign out_is_store = r_out_is_store;
  assign out_misalign = r_out_misalign;

  assign w_head = r_ent[r_head];
  assign w_addr = w_head.vj + w_head.imm;
  assign w_size = w_head.f3[1:0];
  assign w_mis  = (w_size == 2'd1 && w_addr[0]) || (w_size == 2'd2 && w_addr[1:0] != 2'b00);
  assign w_can_issue = (r_state == S_IDLE) && r_busy[r_head] && w_head.j_rdy &&
                       (!w_head.is_store || (w_head.k_rdy && rob_head == w_head.rob));
  assign w_push = in_valid && !full;
  assign w_pop  = ((r_state == S_REQ) && mem_ack) || (w_can_issue && w_mis);

  always_comb begin
    case (w_size)
      2'd0:    w_wdata = {24'b0, w_head.vk[7:0]};
      2'd1:    w_wdata = {16'b0, w_head.vk[15:0]};
      default: w_wdata = w_head.vk;
    endcase
    case (r_cur_f3)
      3'd0:    w_ldval = {{24{mem_rdata[7]}}, mem_rdata[7:0]};
      3'd1:    w_ldval = {{16{mem_rdata[15]}}, mem_rdata[15:0]};
      3'd4:    w_ldval = {24'b0, mem_rdata[7:0]};
      3'd5:    w_ldval = {16'b0, mem_rdata[15:0]};
      default: w_ldval = mem_rdata;
    endcase
  end

  // Incoming op snoops the same-cycle CDB; descending scan lets port 0 win.
  always_comb begin
    w_new.is_store = in_is_store;
    w_new.f3       = in_funct3;
    w_new.vj       = in_vj;
    w_new.vk       = in_vk;
    w_new.imm      = in_imm;
    w_new.qj       = in_qj;
    w_new.qk       = in_qk;
    w_new.rob      = in_rob;
    w_new.j_rdy    = in_j_rdy;
    w_new.k_rdy    = in_k_rdy;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (!in_j_rdy && cdb_valid[p] && cdb_tag[p*ROB_BITS +: ROB_BITS] == in_qj) begin
        w_new.j_rdy = 1'b1;
        w_new.vj    = cdb_value[p*32 +: 32];
      end
      if (!in_k_rdy && cdb_valid[p] && cdb_tag[p*ROB_BITS +: ROB_BITS] == in_qk) begin
        w_new.k_rdy = 1'b1;
        w_new.vk    = cdb_value[p*32 +: 32];
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_busy  <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_busy  <= '0;
        r_head  <= '0;
        r_tail  <= '0;
        r_count <= '0;
      end else begin
        if (w_push) begin
          r_busy[r_tail] <= 1'b1;
          r_tail         <= r_tail + 1'b1;
        end
        if (w_pop) begin
          r_busy[r_head] <= 1'b0;
          r_head         <= r_head + 1'b1;
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // Payload needs no reset: busy bits alone define which entries are live.
  always_ff @(posedge clk_in) begin
    if (rdy_in && !flush) begin
      for (int i = 0; i < DEPTH; i++) begin
        for (int p = NUM_CDB - 1; p >= 0; p--) begin
          if (r_busy[i] && !r_ent[i].j_rdy && cdb_valid[p] &&
              cdb_tag[p*ROB_BITS +: ROB_BITS] == r_ent[i].qj) begin
            r_ent[i].j_rdy <= 1'b1;
            r_ent[i].vj    <= cdb_value[p*32 +: 32];
          end
          if (r_busy[i] && !r_ent[i].k_rdy && cdb_valid[p] &&
              cdb_tag[p*ROB_BITS +: ROB_BITS] == r_ent[i].qk) begin
            r_ent[i].k_rdy <= 1'b1;
            r_ent[i].vk    <= cdb_value[p*32 +: 32];
          end
        end
      end
      if (w_push) r_ent[r_tail] <= w_new;
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state        <= S_IDLE;
      r_cur_rob      <= '0;
      r_cur_f3       <= '0;
      r_mem_req      <= 1'b0;
      r_mem_we       <= 1'b0;
      r_mem_size     <= '0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
      r_out_valid    <= 1'b0;
      r_out_rob      <= '0;
      r_out_value    <= '0;
      r_out_is_store <= 1'b0;
      r_out_misalign <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (rdy_in) begin
        if (flush) begin
          // Unacked request is withdrawn; in-flight load data gets swallowed.
          r_mem_req <= 1'b0;
          case (r_state)
            S_REQ:     r_state <= S_IDLE;
            S_WAIT_LD: r_state <= mem_rvalid ? S_IDLE : S_DROP;
            S_DROP:    if (mem_rvalid) r_state <= S_IDLE;
            default:   r_state <= r_state;
          endcase
        end else begin
          case (r_state)
            S_IDLE: if (w_can_issue) begin
              if (w_mis) begin
                r_out_valid    <= 1'b1;
                r_out_rob      <= w_head.rob;
                r_out_value    <= '0;
                r_out_is_store <= w_head.is_store;
                r_out_misalign <= 1'b1;
              end else begin
                r_mem_req   <= 1'b1;
                r_mem_we    <= w_head.is_store;
                r_mem_size  <= w_size;
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_head.is_store ? w_wdata : 32'b0;
                r_cur_rob   <= w_head.rob;
                r_cur_f3    <= w_head.f3;
                r_state     <= S_REQ;
              end
            end
            S_REQ: if (mem_ack) begin
              r_mem_req <= 1'b0;
              if (r_mem_we) begin
                r_out_valid    <= 1'b1;
                r_out_rob      <= r_cur_rob;
                r_out_value    <= '0;
                r_out_is_store <= 1'b1;
                r_out_misalign <= 1'b0;
                r_state        <= S_IDLE;
              end else begin
                r_state <= S_WAIT_LD;
              end
            end
            S_WAIT_LD: if (mem_rvalid) begin
              r_out_valid    <= 1'b1;
              r_out_rob      <= r_cur_rob;
              r_out_value    <= w_ldval;
              r_out_is_store <= 1'b0;
              r_out_misalign <= 1'b0;
              r_state        <= S_IDLE;
            end
            default: if (mem_rvalid) r_state <= S_IDLE;
          endcase
        end
      end
    end
  end
endmodule

// File: tb/tb_lsq.sv
// Directed bench for lsq: loads, stores, occupancy, CDB wakeup, misalign, flush, stall.
module tb_lsq;
  localparam int DEPTH = 8, RB = 4, NC = 2;

  logic clk = 1'b0, rst, rdy_in, in_valid, in_is_store, in_j_rdy, in_k_rdy;
  logic [2:0] in_funct3;
  logic [31:0] in_vj, in_vk, in_imm;
  logic [RB-1:0] in_qj, in_qk, in_rob, rob_head, out_rob;
  logic full, flush, mem_req, mem_we, mem_ack, mem_rvalid, out_valid, out_is_store, out_misalign;
  logic [3:0] count;
  logic [NC-1:0] cdb_valid;
  logic [NC*RB-1:0] cdb_tag;
  logic [NC*32-1:0] cdb_value;
  logic [1:0] mem_size;
  logic [31:0] mem_addr, mem_wdata, mem_rdata, out_value;

  always #5 clk = ~clk;

  lsq #(.DEPTH(DEPTH), .ROB_BITS(RB), .NUM_CDB(NC)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy_in), .in_valid(in_valid), .in_is_store(in_is_store),
    .in_funct3(in_funct3), .in_vj(in_vj), .in_vk(in_vk), .in_qj(in_qj), .in_qk(in_qk),
    .in_j_rdy(in_j_rdy), .in_k_rdy(in_k_rdy), .in_imm(in_imm), .in_rob(in_rob),
    .full(full), .count(count), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rob_head(rob_head), .flush(flush), .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .out_valid(out_valid), .out_rob(out_rob), .out_value(out_value),
    .out_is_store(out_is_store), .out_misalign(out_misalign)
  );

  int tests = 0, fails = 0;
  int ov_cnt = 0, req_cyc = 0;
  logic [31:0] last_val;
  logic [RB-1:0] last_rob;
  logic last_st, last_mis;

  always @(negedge clk) begin
    if (out_valid) begin
      ov_cnt   <= ov_cnt + 1;
      last_val <= out_value;
      last_rob <= out_rob;
      last_st  <= out_is_store;
      last_mis <= out_misalign;
    end
    if (mem_req) req_cyc <= req_cyc + 1;
  end

  task automatic tick; @(posedge clk); #1; endtask

  task automatic set_in(input logic st, input logic [2:0] f3, input logic [31:0] vj, vk, imm,
                        input logic [RB-1:0] rob, input logic jr, kr, input logic [RB-1:0] qj, qk);
    in_is_store = st; in_funct3 = f3; in_vj = vj; in_vk = vk; in_imm = imm;
    in_rob = rob; in_j_rdy = jr; in_k_rdy = kr; in_qj = qj; in_qk = qk;
  endtask

  task automatic push(input logic st, input logic [2:0] f3, input logic [31:0] vj, vk, imm,
                      input logic [RB-1:0] rob);
    set_in(st, f3, vj, vk, imm, rob, 1'b1, 1'b1, '0, '0);
    in_valid = 1'b1; tick; in_valid = 1'b0;
  endtask

  task automatic wait_req(output bit got);
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (mem_req) got = 1'b1; else tick;
    end
  endtask

  task automatic ack; mem_ack = 1'b1; tick; mem_ack = 1'b0; endtask
  task automatic rvalid(input logic [31:0] d); mem_rvalid = 1'b1; mem_rdata = d; tick; mem_rvalid = 1'b0; endtask

  task automatic run_load(input logic [2:0] f3, input logic [31:0] vj, imm, input logic [RB-1:0] rob,
                          input logic [31:0] rdata, output bit got, output logic [31:0] addr,
                          output logic [1:0] size, output int ovd);
    int o0;
    push(1'b0, f3, vj, 32'h0, imm, rob);
    o0 = ov_cnt;
    wait_req(got);
    addr = mem_addr; size = mem_size;
    if (got) begin ack; rvalid(rdata); tick; end
    ovd = ov_cnt - o0;
  endtask

  task automatic test_reset;
    rst = 1'b1; rdy_in = 1'b1; in_valid = 1'b0; flush = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    mem_rdata = '0; cdb_valid = '0; cdb_tag = '0; cdb_value = '0; rob_head = '0;
    set_in(1'b0, 3'd0, '0, '0, '0, '0, 1'b0, 1'b0, '0, '0);
    #12;
    tests++; if ({mem_req, out_valid, full, count} !== 7'b0) begin fails++; $display("FAIL reset_outputs got %b exp 0", {mem_req, out_valid, full, count}); end
    rst = 1'b0; tick; tick;
    tests++; if (count !== 4'd0 || mem_req !== 1'b0) begin fails++; $display("FAIL post_reset got count=%0d req=%b exp 0", count, mem_req); end
  endtask

  task automatic test_lw;
    bit got; logic [31:0] a; logic [1:0] s; int ovd;
    run_load(3'd2, 32'h100, 32'h4, 4'd2, 32'hDEADBEEF, got, a, s, ovd);
    tests++; if (!got) begin fails++; $display("FAIL lw_req timeout"); end
    tests++; if (a !== 32'h104 || s !== 2'd2) begin fails++; $display("FAIL lw_addr got %h/%0d exp 104/2", a, s); end
    tests++; if (ovd !== 1 || last_val !== 32'hDEADBEEF || last_rob !== 4'd2 || last_st !== 1'b0)
      begin fails++; $display("FAIL lw_data got n=%0d v=%h rob=%0d exp 1 deadbeef 2", ovd, last_val, last_rob); end
    tests++; if (count !== 4'd0 || mem_req !== 1'b0) begin fails++; $display("FAIL lw_drain got count=%0d req=%b exp 0", count, mem_req); end
  endtask

  task automatic test_extend;
    bit got; logic [31:0] a; logic [1:0] s; int ovd;
    run_load(3'd0, 32'h200, 32'h0, 4'd3, 32'h00000080, got, a, s, ovd);
    tests++; if (!got || ovd !== 1 || last_val !== 32'hFFFFFF80 || s !== 2'd0)
      begin fails++; $display("FAIL lb_sext got %h size %0d exp ffffff80 0", last_val, s); end
    run_load(3'd4, 32'h200, 32'h0, 4'd4, 32'h00000080, got, a, s, ovd);
    tests++; if (!got || ovd !== 1 || last_val !== 32'h00000080)
      begin fails++; $display("FAIL lbu_zext got %h exp 00000080", last_val); end
    run_load(3'd1, 32'h202, 32'h0, 4'd5, 32'h1234_8001, got, a, s, ovd);
    tests++; if (!got || ovd !== 1 || last_val !== 32'hFFFF8001 || s !== 2'd1)
      begin fails++; $display("FAIL lh_sext got %h exp ffff8001", last_val); end
  endtask

  task automatic test_store;
    bit got; int r0, o0;
    rob_head = 4'd1;
    push(1'b1, 3'd2, 32'h300, 32'hCAFEF00D, 32'h0, 4'd3);
    r0 = req_cyc;
    repeat (5) tick;
    tests++; if (req_cyc !== r0 || mem_req !== 1'b0) begin fails++; $display("FAIL sw_not_head got req cycles %0d exp 0", req_cyc - r0); end
    rob_head = 4'd3;
    wait_req(got);
    tests++; if (!got || mem_we !== 1'b1 || mem_wdata !== 32'hCAFEF00D || mem_addr !== 32'h300 || mem_size !== 2'd2)
      begin fails++; $display("FAIL sw_req got we=%b wd=%h a=%h exp 1 cafef00d 300", mem_we, mem_wdata, mem_addr); end
    o0 = ov_cnt;
    ack; tick;
    tests++; if (ov_cnt !== o0 + 1 || last_st !== 1'b1 || last_rob !== 4'd3 || last_val !== 32'h0)
      begin fails++; $display("FAIL sw_done got n=%0d st=%b rob=%0d v=%h exp 1 1 3 0", ov_cnt - o0, last_st, last_rob, last_val); end
    rob_head = 4'd4;
    push(1'b1, 3'd0, 32'h310, 32'h12345678, 32'h0, 4'd4);
    wait_req(got);
    tests++; if (!got || mem_wdata !== 32'h78 || mem_size !== 2'd0)
      begin fails++; $display("FAIL sb_wdata got %h size %0d exp 78 0", mem_wdata, mem_size); end
    ack; tick;
  endtask

  task automatic test_full;
    bit got; logic [31:0] exp_a;
    rob_head = 4'd0;
    for (int i = 0; i < DEPTH; i++) push(1'b1, 3'd2, 32'h1000 + 32'(i * 4), 32'(i), 32'h0, 4'd7);
    tests++; if (full !== 1'b1 || count !== 4'd8 || mem_req !== 1'b0)
      begin fails++; $display("FAIL full_flag got full=%b count=%0d exp 1 8", full, count); end
    push(1'b1, 3'd2, 32'hBAD0, 32'h0, 32'h0, 4'd7);
    tests++; if (count !== 4'd8) begin fails++; $display("FAIL full_ignore got count=%0d exp 8", count); end
    rob_head = 4'd7;
    wait_req(got);
    tests++; if (!got || mem_addr !== 32'h1000) begin fails++; $display("FAIL full_first got %h exp 1000", mem_addr); end
    ack;
    wait_req(got);
    set_in(1'b1, 3'd2, 32'h2000, 32'h0, 32'h0, 4'd7, 1'b1, 1'b1, '0, '0);
    in_valid = 1'b1; mem_ack = 1'b1; tick; in_valid = 1'b0; mem_ack = 1'b0;
    tests++; if (count !== 4'd7) begin fails++; $display("FAIL push_pop_count got %0d exp 7", count); end
    for (int k = 0; k < 7; k++) begin
      exp_a = (k < 6) ? 32'h1008 + 32'(k * 4) : 32'h2000;
      wait_req(got);
      tests++; if (!got || mem_addr !== exp_a) begin fails++; $display("FAIL wrap_order[%0d] got %h exp %h", k, mem_addr, exp_a); end
      ack;
    end
    tick;
    tests++; if (count !== 4'd0 || full !== 1'b0) begin fails++; $display("FAIL full_drain got count=%0d exp 0", count); end
  endtask

  task automatic test_cdb;
    bit got; int r0;
    rob_head = 4'd6;
    cdb_valid = 2'b11; cdb_tag = {4'd5, 4'd9}; cdb_value = {32'h200, 32'h999};
    set_in(1'b1, 3'd2, 32'h0, 32'h55, 32'h10, 4'd6, 1'b0, 1'b1, 4'd5, 4'd0);
    in_valid = 1'b1; tick; in_valid = 1'b0; cdb_valid = '0;
    wait_req(got);
    tests++; if (!got || mem_addr !== 32'h210 || mem_wdata !== 32'h55)
      begin fails++; $display("FAIL cdb_push got a=%h wd=%h exp 210 55", mem_addr, mem_wdata); end
    ack; tick;
    set_in(1'b0, 3'd2, 32'h0, 32'h0, 32'h8, 4'd9, 1'b0, 1'b1, 4'd2, 4'd0);
    in_valid = 1'b1; tick; in_valid = 1'b0;
    r0 = req_cyc;
    repeat (3) tick;
    tests++; if (req_cyc !== r0) begin fails++; $display("FAIL cdb_wait got req cycles %0d exp 0", req_cyc - r0); end
    cdb_valid = 2'b11; cdb_tag = {4'd2, 4'd2}; cdb_value = {32'h800, 32'h400};
    tick; cdb_valid = '0;
    wait_req(got);
    tests++; if (!got || mem_addr !== 32'h408) begin fails++; $display("FAIL cdb_prio got %h exp 408", mem_addr); end
    ack; rvalid(32'h0); tick;
  endtask

  task automatic test_misalign;
    int r0, o0;
    r0 = req_cyc; o0 = ov_cnt;
    push(1'b0, 3'd1, 32'h101, 32'h0, 32'h0, 4'd8);
    repeat (3) tick;
    tests++; if (req_cyc !== r0 || ov_cnt !== o0 + 1 || last_mis !== 1'b1 || last_rob !== 4'd8 || count !== 4'd0)
      begin fails++; $display("FAIL lh_misalign got req=%0d n=%0d mis=%b rob=%0d exp 0 1 1 8", req_cyc - r0, ov_cnt - o0, last_mis, last_rob); end
    push(1'b0, 3'd2, 32'h100, 32'h0, 32'h2, 4'd9);
    repeat (3) tick;
    tests++; if (req_cyc !== r0 || ov_cnt !== o0 + 2 || last_mis !== 1'b1 || last_rob !== 4'd9)
      begin fails++; $display("FAIL lw_misalign got req=%0d n=%0d mis=%b exp 0 2 1", req_cyc - r0, ov_cnt - o0, last_mis); end
  endtask

  task automatic test_flush;
    bit got; int r0, o0;
    push(1'b0, 3'd2, 32'h40, 32'h0, 32'h0, 4'd1);
    wait_req(got); ack;
    flush = 1'b1; tick; flush = 1'b0;
    push(1'b0, 3'd2, 32'h44, 32'h0, 32'h0, 4'd2);
    r0 = req_cyc;
    repeat (3) tick;
    tests++; if (req_cyc !== r0) begin fails++; $display("FAIL drop_blocks got req cycles %0d exp 0", req_cyc - r0); end
    o0 = ov_cnt;
    rvalid(32'h11111111); tick;
    tests++; if (ov_cnt !== o0) begin fails++; $display("FAIL drop_swallow got %0d pulses exp 0", ov_cnt - o0); end
    wait_req(got);
    tests++; if (!got || mem_addr !== 32'h44) begin fails++; $display("FAIL after_drop got %h exp 44", mem_addr); end
    ack; rvalid(32'h22222222); tick;
    tests++; if (ov_cnt !== o0 + 1 || last_val !== 32'h22222222 || last_rob !== 4'd2)
      begin fails++; $display("FAIL after_drop_data got %h rob %0d exp 22222222 2", last_val, last_rob); end
    push(1'b0, 3'd2, 32'h50, 32'h0, 32'h0, 4'd3);
    wait_req(got);
    flush = 1'b1; tick; flush = 1'b0;
    r0 = req_cyc;
    repeat (3) tick;
    tests++; if (mem_req !== 1'b0 || count !== 4'd0 || req_cyc !== r0)
      begin fails++; $display("FAIL flush_req got req=%b count=%0d exp 0 0", mem_req, count); end
  endtask

  task automatic test_stall;
    bit got; int o0;
    rdy_in = 1'b0;
    set_in(1'b0, 3'd2, 32'h60, 32'h0, 32'h0, 4'd4, 1'b1, 1'b1, '0, '0);
    in_valid = 1'b1; tick; in_valid = 1'b0;
    tests++; if (count !== 4'd0) begin fails++; $display("FAIL stall_push got count=%0d exp 0", count); end
    rdy_in = 1'b1;
    push(1'b0, 3'd2, 32'h64, 32'h0, 32'h0, 4'd5);
    wait_req(got);
    rdy_in = 1'b0; mem_ack = 1'b1; tick; tick; mem_ack = 1'b0;
    tests++; if (!got || mem_req !== 1'b1 || count !== 4'd1) begin fails++; $display("FAIL stall_hold got req=%b count=%0d exp 1 1", mem_req, count); end
    rdy_in = 1'b1;
    o0 = ov_cnt;
    ack; rvalid(32'hA5A5A5A5); tick;
    tests++; if (ov_cnt !== o0 + 1 || last_val !== 32'hA5A5A5A5) begin fails++; $display("FAIL stall_resume got %h exp a5a5a5a5", last_val); end
  endtask

  initial begin
    test_reset;
    test_lw;
    test_extend;
    test_store;
    test_full;
    test_cdb;
    test_misalign;
    test_flush;
    test_stall;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/lsq.md
# lsq

Parametrised load/store queue between dispatch and the memory controller; successor to the fixed-size load/store buffer. Holds memory ops in program order, wakes operands from a configurable number of CDB ports, and issues one op at a time to memory. Stores issue only at ROB head. Adds over the previous generation: misaligned-address detection, count-based occupancy, and suppression of load data still in flight across a flush.

## Interface
- DEPTH, 8, queue entries; power of two, ≥2
- ROB_BITS, 4, ROB tag width
- NUM_CDB, 2, wakeup broadcast ports
- clk_in  in  1  clock, rising edge
- rst_in  in  1  reset; asynchronous, active-high
- rdy_in  in  1  global enable; low freezes all state
- in_valid  in  1  push one op
- in_is_store  in  1  0 load, 1 store
- in_funct3  in  3  LB=0 LH=1 LW=2 LBU=4 LHU=5; SB=0 SH=1 SW=2
- in_vj, in_vk  in  32  base / store data values
- in_qj, in_qk  in  ROB_BITS  producer tags
- in_j_rdy, in_k_rdy  in  1  operand already valid
- in_imm  in  32  offset
- in_rob  in  ROB_BITS  own ROB tag
- full  out  1  count==DEPTH
- count  out  log2(DEPTH)+1  occupancy
- cdb_valid  in  NUM_CDB  per-port broadcast valid
- cdb_tag  in  NUM_CDB*ROB_BITS  flattened, port p at [p*ROB_BITS +: ROB_BITS]
- cdb_value  in  NUM_CDB*32  flattened
- rob_head  in  ROB_BITS  oldest uncommitted tag
- flush  in  1  mispredict clear
- mem_req  out  1  request valid, held until mem_ack
- mem_we  out  1  1 store
- mem_size  out  2  0 byte, 1 half, 2 word
- mem_addr  out  32  vj+imm
- mem_wdata  out  32  vk masked to size
- mem_ack  in  1  request accepted
- mem_rvalid, mem_rdata  in  1, 32  load data return
- out_valid  out  1  one-cycle completion pulse
- out_rob  out  ROB_BITS  completing tag
- out_value  out  32  extended load data; 0 for stores
- out_is_store, out_misalign  out  1  completion kind / fault

## Operation
- Circular buffer, head/tail pointers wrap modulo DEPTH; count tracks occupancy; empty = count==0.
- Push when in_valid && !full; in_valid while full ignored. Push and pop in one cycle: count unchanged.
- Wakeup: each cycle every busy entry with operand not ready compares against each valid CDB port; match sets ready and captures value. Pushing op also compares in_qj/in_qk against same-cycle CDB. Multiple ports matching one tag: lowest port wins.
- States: IDLE, REQ, WAIT_LD, DROP.
- IDLE: head busy and j ready (and k ready for store) and (load, or store with rob_head==head tag): compute addr. Misaligned (half addr[0]=1, word addr[1:0]≠0): pop, pulse out_valid with out_misalign=1, no memory access. Else assert mem_req → REQ.
- REQ: outputs stable until mem_ack. On ack pop head; store → out_valid, out_is_store=1 next cycle, → IDLE; load → WAIT_LD.
- WAIT_LD: on mem_rvalid pulse out_valid with out_value = LB/LH sign-extended, LBU/LHU zero-extended, LW raw → IDLE. Load result not broadcast back into queue internally; it returns via CDB.
- flush: all entries cleared, count=0, mem_req dropped. In REQ: request withdrawn (controller must not act on unacked req). In WAIT_LD: → DROP. DROP swallows next mem_rvalid, no out_valid, → IDLE; IDLE may not issue a load while in DROP. flush beats in_valid same cycle.
- Only one memory op outstanding.

## Timing
- Reset: all outputs 0, count 0, pointers 0, state IDLE, entries not busy.
- Push → earliest mem_req next cycle (entry with ready operands).
- mem_ack cycle N → store out_valid at N+1; misaligned out_valid one cycle after detection.
- Load out_valid one cycle after mem_rvalid.
- CDB wakeup visible to issue logic one cycle after broadcast.
- rdy_in low: no push, pop, wakeup or state change; mem_req held.

## Test plan
- Push LW vj=0x100 imm=4 ready → mem_req, addr 0x104, size 2; ack, rdata 0xDEADBEEF → out_valid value 0xDEADBEEF.
- LB with rdata 0x80 → 0xFFFFFF80; LBU same → 0x00000080.
- SW tag 3, rob_head=1 → no mem_req; rob_head=3 → mem_req, we=1, wdata=vk; SB vk=0x12345678 → wdata 0x78.
- Push DEPTH ops, no issue → full=1, count=DEPTH, extra push ignored; pop+push same cycle keeps count; tail wraps correctly.
- Store base waits on tag 5; cdb port 1 broadcasts tag 5 value 0x200 same cycle as push → addr 0x200+imm.
- LH addr 0x101 → out_misalign=1, no mem_req; flush in WAIT_LD → following mem_rvalid produces no out_valid, next load completes normally.
